// File: rtl/butterfly_pkg.sv
// Shared types and helpers for the radix-4 butterfly pipeline.
package butterfly_pkg;

  // Widest sample supported by the pipeline. cplx_t carries W+2 bits for this width,
  // so any legal W (8..32) fits after sign extension.
  localparam int MAX_W  = 32;
  localparam int CPLX_W = MAX_W + 2;

  // Output scaling codes. Code 3 is treated the same as SCALE_QUARTER.
  localparam logic [1:0] SCALE_1X      = 2'd0;
  localparam logic [1:0] SCALE_HALF    = 2'd1;
  localparam logic [1:0] SCALE_QUARTER = 2'd2;

  typedef struct packed {
    logic signed [CPLX_W-1:0] r;
    logic signed [CPLX_W-1:0] i;
  } cplx_t;

  // Multiply by -j (inv=0, forward) or +j (inv=1, inverse). This only swaps and negates
  // the components, so no multiplier is needed.
  function automatic cplx_t mul_j(input cplx_t c, input logic inv);
    cplx_t res;
    if (inv) begin
      res.r = -c.i;
      res.i = c.r;
    end else begin
      res.r = c.i;
      res.i = -c.r;
    end
    return res;
  endfunction

endpackage

// File: rtl/butterfly_round_sat.sv
// Combinational round-half-up, arithmetic right shift and saturation of one
// (W+2)-bit butterfly component down to W bits.
module butterfly_round_sat
  import butterfly_pkg::*;
#(
  parameter int W = 16
) (
  input  logic signed [W+1:0] i_raw,
  input  logic [1:0]          i_scale,
  output logic signed [W-1:0] o_res,
  output logic                o_sat
);

  // One guard bit above the raw width keeps the rounding add exact for every input.
  localparam logic signed [W+2:0] MAX_V = {4'b0000, {(W-1){1'b1}}};
  localparam logic signed [W+2:0] MIN_V = {4'b1111, {(W-1){1'b0}}};

  logic signed [W+2:0] w_ext;
  logic signed [W+2:0] w_sum;
  logic signed [W+2:0] w_shift;

  // Add half an output LSB, then shift; code 3 falls into the quarter-scale branch.
  always_comb begin
    // NOTE: every combinational output gets a default first so that no path can infer a latch.
    w_ext   = {i_raw[W+1], i_raw};
    w_sum   = w_ext;
    w_shift = w_ext;
    case (i_scale)
      SCALE_1X: begin
        w_sum   = w_ext;
        w_shift = w_sum;
      end
      SCALE_HALF: begin
        w_sum   = w_ext + (W+3)'(1);
        w_shift = w_sum >>> 1;
      end
      default: begin
        w_sum   = w_ext + (W+3)'(2);
        w_shift = w_sum >>> 2;
      end
    endcase
  end

  // Clamp to the W-bit two's complement range and flag when clamping happened.
  always_comb begin
    o_sat = 1'b0;
    o_res = w_shift[W-1:0];
    if (w_shift > MAX_V) begin
      o_sat = 1'b1;
      o_res = MAX_V[W-1:0];
    end else if (w_shift < MIN_V) begin
      o_sat = 1'b1;
      o_res = MIN_V[W-1:0];
    end
  end

endmodule

// File: rtl/radix4_butterfly_pipe.sv
// Two-stage pipelined radix-4 complex butterfly with valid/ready handshake,
// per-transaction forward/inverse, output scaling and a sticky overflow flag.
module radix4_butterfly_pipe
  import butterfly_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] Ar,
  input  logic signed [W-1:0] Ai,
  input  logic signed [W-1:0] Br,
  input  logic signed [W-1:0] Bi,
  input  logic signed [W-1:0] Cr,
  input  logic signed [W-1:0] Ci,
  input  logic signed [W-1:0] Dr,
  input  logic signed [W-1:0] Di,
  input  logic                inverse,
  input  logic [1:0]          scale,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out0r,
  output logic signed [W-1:0] out0i,
  output logic signed [W-1:0] out1r,
  output logic signed [W-1:0] out1i,
  output logic signed [W-1:0] out2r,
  output logic signed [W-1:0] out2i,
  output logic signed [W-1:0] out3r,
  output logic signed [W-1:0] out3i,
  output logic                ovf,
  input  logic                clr_ovf
);

  // Stage 1 state: partial sums/differences (W+1 bits) plus the per-transaction controls.
  logic                r_v1;
  logic signed [W:0]   r_sac_r, r_sac_i, r_dac_r, r_dac_i;
  logic signed [W:0]   r_sbd_r, r_sbd_i, r_dbd_r, r_dbd_i;
  logic                r_inv1;
  logic [1:0]          r_scale1;

  // Stage 2 state: registered outputs, ordered 0r,0i,1r,1i,2r,2i,3r,3i.
  logic                r_v2;
  logic signed [W-1:0] r_out [8];
  logic                r_ovf;

  logic                w_en1;
  logic                w_en2;
  cplx_t               w_sac, w_dac, w_sbd, w_dbd, w_rot;
  logic signed [W+1:0] w_raw [8];
  logic signed [W-1:0] w_res [8];
  logic [7:0]          w_sat;

  // A stage may load when it is empty or when the stage after it is moving; the
  // out_ready -> in_ready path is combinational so bubbles collapse.
  assign w_en2    = !r_v2 || out_ready;
  assign w_en1    = !r_v1 || w_en2;
  assign in_ready = w_en1;

  // Stage 1: capture the four radix-2 partial terms of the incoming transaction.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_v1     <= 1'b0;
      r_sac_r  <= '0;
      r_sac_i  <= '0;
      r_dac_r  <= '0;
      r_dac_i  <= '0;
      r_sbd_r  <= '0;
      r_sbd_i  <= '0;
      r_dbd_r  <= '0;
      r_dbd_i  <= '0;
      r_inv1   <= 1'b0;
      r_scale1 <= SCALE_1X;
    end else if (w_en1) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_sac_r  <= {Ar[W-1], Ar} + {Cr[W-1], Cr};
        r_sac_i  <= {Ai[W-1], Ai} + {Ci[W-1], Ci};
        r_dac_r  <= {Ar[W-1], Ar} - {Cr[W-1], Cr};
        r_dac_i  <= {Ai[W-1], Ai} - {Ci[W-1], Ci};
        r_sbd_r  <= {Br[W-1], Br} + {Dr[W-1], Dr};
        r_sbd_i  <= {Bi[W-1], Bi} + {Di[W-1], Di};
        r_dbd_r  <= {Br[W-1], Br} - {Dr[W-1], Dr};
        r_dbd_i  <= {Bi[W-1], Bi} - {Di[W-1], Di};
        r_inv1   <= inverse;
        r_scale1 <= scale;
      end
    end
  end

  // Stage 2 combine: out1/out3 take (A-C) -/+ j(B-D); the direction comes from mul_j.
  always_comb begin
    w_sac.r = CPLX_W'(r_sac_r);
    w_sac.i = CPLX_W'(r_sac_i);
    w_dac.r = CPLX_W'(r_dac_r);
    w_dac.i = CPLX_W'(r_dac_i);
    w_sbd.r = CPLX_W'(r_sbd_r);
    w_sbd.i = CPLX_W'(r_sbd_i);
    w_dbd.r = CPLX_W'(r_dbd_r);
    w_dbd.i = CPLX_W'(r_dbd_i);
    w_rot   = mul_j(w_dbd, r_inv1);
    w_raw[0] = (W+2)'(w_sac.r + w_sbd.r);
    w_raw[1] = (W+2)'(w_sac.i + w_sbd.i);
    w_raw[2] = (W+2)'(w_dac.r + w_rot.r);
    w_raw[3] = (W+2)'(w_dac.i + w_rot.i);
    w_raw[4] = (W+2)'(w_sac.r - w_sbd.r);
    w_raw[5] = (W+2)'(w_sac.i - w_sbd.i);
    w_raw[6] = (W+2)'(w_dac.r - w_rot.r);
    w_raw[7] = (W+2)'(w_dac.i - w_rot.i);
  end

  for (genvar k = 0; k < 8; k++) begin : g_rs
    butterfly_round_sat #(.W(W)) u_rs (
      .i_raw   (w_raw[k]),
      .i_scale (r_scale1),
      .o_res   (w_res[k]),
      .o_sat   (w_sat[k])
    );
  end

  // Stage 2 register: outputs hold while stalled, and change only when a transaction lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2 <= 1'b0;
      for (int k = 0; k < 8; k++) r_out[k] <= '0;
    end else if (w_en2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        for (int k = 0; k < 8; k++) r_out[k] <= w_res[k];
      end
    end
  end

  // Sticky overflow: a saturating transaction landing this cycle beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_en2 && r_v1 && (|w_sat)) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  assign out_valid = r_v2;
  assign ovf       = r_ovf;
  assign out0r     = r_out[0];
  assign out0i     = r_out[1];
  assign out1r     = r_out[2];
  assign out1i     = r_out[3];
  assign out2r     = r_out[4];
  assign out2i     = r_out[5];
  assign out3r     = r_out[6];
  assign out3i     = r_out[7];

endmodule

// File: tb/tb_radix4_butterfly_pipe.sv
// Directed self-checking bench for radix4_butterfly_pipe (W=16) with hand-computed vectors.
module tb_radix4_butterfly_pipe;

  localparam int W = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [W-1:0] ar = '0, ai = '0, br = '0, bi = '0;
  logic signed [W-1:0] cr = '0, ci = '0, dr = '0, di = '0;
  logic                inverse = 1'b0;
  logic [1:0]          scale = 2'd0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic signed [W-1:0] o0r, o0i, o1r, o1i, o2r, o2i, o3r, o3i;
  logic                ovf;
  logic                clr_ovf = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  radix4_butterfly_pipe #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Ar        (ar),
    .Ai        (ai),
    .Br        (br),
    .Bi        (bi),
    .Cr        (cr),
    .Ci        (ci),
    .Dr        (dr),
    .Di        (di),
    .inverse   (inverse),
    .scale     (scale),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out0r     (o0r),
    .out0i     (o0i),
    .out1r     (o1r),
    .out1i     (o1i),
    .out2r     (o2r),
    .out2i     (o2i),
    .out3r     (o3r),
    .out3i     (o3i),
    .ovf       (ovf),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_in(input int v[8], input logic inv, input logic [1:0] sc);
    ar = W'(v[0]); ai = W'(v[1]); br = W'(v[2]); bi = W'(v[3]);
    cr = W'(v[4]); ci = W'(v[5]); dr = W'(v[6]); di = W'(v[7]);
    inverse = inv;
    scale   = sc;
  endtask

  task automatic read_out(output int o[8]);
    o[0] = int'(o0r); o[1] = int'(o0i); o[2] = int'(o1r); o[3] = int'(o1i);
    o[4] = int'(o2r); o[5] = int'(o2i); o[6] = int'(o3r); o[7] = int'(o3i);
  endtask

  // Send one transaction with out_ready high, wait (bounded) for it, compare all 8 outputs.
  task automatic run_one(input string tag, input int v[8], input logic inv,
                         input logic [1:0] sc, input int e[8]);
    int o[8];
    int lat;
    @(negedge clk);
    set_in(v, inv, sc);
    in_valid = 1'b1;
    #1;
    check({tag, "_in_ready"}, longint'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, lat, 2);
    check({tag, "_out_valid"}, longint'(out_valid), 1);
    read_out(o);
    for (int k = 0; k < 8; k++) check($sformatf("%s_out[%0d]", tag, k), o[k], e[k]);
  endtask

  initial begin
    int v[8];
    int e[8];
    int o[8];
    int prev[8];
    int sent;
    int got;
    logic stall_prev;
    logic acc;
    logic seen_valid;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_ovf", longint'(ovf), 0);
    check("reset_in_ready", longint'(in_ready), 1);
    read_out(o);
    for (int k = 0; k < 8; k++) check($sformatf("reset_out[%0d]", k), o[k], 0);

    // Impulse
    v = '{100, 0, 0, 0, 0, 0, 0, 0};
    e = '{100, 0, 100, 0, 100, 0, 100, 0};
    run_one("impulse", v, 1'b0, 2'd0, e);
    check("impulse_ovf", longint'(ovf), 0);

    // j-rotation, forward then inverse
    v = '{0, 0, 100, 0, 0, 0, 0, 0};
    e = '{100, 0, 0, -100, -100, 0, 0, 100};
    run_one("jrot_fwd", v, 1'b0, 2'd0, e);
    e = '{100, 0, 0, 100, -100, 0, 0, -100};
    run_one("jrot_inv", v, 1'b1, 2'd0, e);

    // DC
    v = '{1000, -1000, 1000, -1000, 1000, -1000, 1000, -1000};
    e = '{4000, -4000, 0, 0, 0, 0, 0, 0};
    run_one("dc", v, 1'b0, 2'd0, e);
    check("dc_ovf", longint'(ovf), 0);

    // Rounding
    v = '{3, -3, 0, 0, 0, 0, 0, 0};
    e = '{1, -1, 1, -1, 1, -1, 1, -1};
    run_one("round_q", v, 1'b0, 2'd2, e);
    v = '{2, 0, 0, 0, 0, 0, 0, 0};
    e = '{1, 0, 1, 0, 1, 0, 1, 0};
    run_one("round_h", v, 1'b0, 2'd1, e);
    check("round_ovf", longint'(ovf), 0);

    // Saturation at scale 0 sets ovf
    v = '{32767, 0, 32767, 0, 32767, 0, 32767, 0};
    e = '{32767, 0, 0, 0, 0, 0, 0, 0};
    run_one("sat_s0", v, 1'b0, 2'd0, e);
    check("sat_s0_ovf", longint'(ovf), 1);

    // Clear alone
    @(negedge clk) clr_ovf = 1'b1;
    @(posedge clk);
    #1 clr_ovf = 1'b0;
    check("clr_alone_ovf", longint'(ovf), 0);

    // Same input at scale 2 fits without saturation
    run_one("sat_s2", v, 1'b0, 2'd2, e);
    check("sat_s2_ovf", longint'(ovf), 0);

    // Clear asserted on the edge a saturating transaction lands: set wins
    @(negedge clk);
    set_in(v, 1'b0, 2'd0);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    clr_ovf = 1'b1;
    @(posedge clk);
    #1 clr_ovf = 1'b0;
    check("clr_set_out_valid", longint'(out_valid), 1);
    check("clr_set_ovf", longint'(ovf), 1);
    @(negedge clk) clr_ovf = 1'b1;
    @(posedge clk);
    #1 clr_ovf = 1'b0;
    check("clr_again_ovf", longint'(ovf), 0);

    // Backpressure: 6 back-to-back transactions, out_ready low in cycles 3..6
    sent = 0;
    got = 0;
    stall_prev = 1'b0;
    prev = '{default: 0};
    @(negedge clk);
    for (int c = 0; c < 40 && got < 6; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      if (sent < 6) begin
        v = '{default: 0};
        v[0] = (sent + 1) * 10;
        set_in(v, 1'b0, 2'd0);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      read_out(o);
      if (stall_prev) begin
        check("bp_hold_valid", longint'(out_valid), 1);
        for (int k = 0; k < 8; k++) check($sformatf("bp_stable[%0d]", k), o[k], prev[k]);
      end
      if (sent - got == 2 && !out_ready) check("bp_in_ready_low", longint'(in_ready), 0);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        check($sformatf("bp_out0r_%0d", got), o[0], (got + 1) * 10);
        check($sformatf("bp_out3r_%0d", got), o[6], (got + 1) * 10);
        check($sformatf("bp_out1i_%0d", got), o[3], 0);
        got++;
      end
      stall_prev = out_valid && !out_ready;
      prev = o;
      if (acc) sent++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp_count", got, 6);
    check("bp_sent", sent, 6);

    // Reset with both stages full discards everything
    @(negedge clk);
    out_ready = 1'b0;
    v = '{7, 7, 0, 0, 0, 0, 0, 0};
    set_in(v, 1'b0, 2'd0);
    in_valid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("full_in_ready", longint'(in_ready), 0);
    check("full_out_valid", longint'(out_valid), 1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_out_valid", longint'(out_valid), 0);
    read_out(o);
    for (int k = 0; k < 8; k++) check($sformatf("rst_mid_out[%0d]", k), o[k], 0);
    @(negedge clk) rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst_mid_in_ready", longint'(in_ready), 1);
    seen_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    check("rst_mid_no_output", longint'(seen_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
